// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer
//
// Avalon-MM initiator that runs the 16-bit-register interval timer slave on
// its own, without the Nios CPU. It programs the period, starts the timer,
// services the timeout IRQ and emits one tick pulse per serviced timeout. On
// request it also captures a live counter snapshot from the slave.
//
// Slave register map (index on o_avm_address):
//   0 status   (write clears timeout)
//   1 control  {stop, start, cont, ito}
//   2 period_l
//   3 period_h
//   4 snap_l   (write latches the live counter)
//   5 snap_h
//
// Ports:
//   i_clk              system clock
//   i_reset            synchronous, active-high reset
//   i_start            pulse: latch i_period_in and program the timer (IDLE only)
//   i_stop             pulse: halt the timer and clear its status
//   i_period_in[31:0]  timeout period in clock cycles minus 1
//   i_snap_req         pulse: request a counter snapshot (RUN only)
//   o_avm_address[2:0] timer register index
//   o_avm_chipselect   asserted for writes only
//   o_avm_write_n      active-low write strobe
//   o_avm_writedata    write data
//   i_avm_readdata     read data, valid the cycle after the address
//   i_irq_in           timer interrupt (level)
//   o_tick             one-cycle pulse per serviced timeout
//   o_tick_count       serviced timeouts since the last start (wraps)
//   o_busy             high in every state except IDLE
//   o_snapshot         last captured counter value
//   o_snapshot_valid   one-cycle pulse when o_snapshot is updated
//
// Parameters:
//   CONTINUOUS  1 = periodic timer, 0 = one-shot (back to IDLE after a tick)
//   MIN_PERIOD  lower clamp applied to i_period_in when it is latched
// ---------------------------------------------------------------------------
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | timer not controlled, waiting for start
// S_WR_PL    | writing period low half
// S_WR_PH    | writing period high half
// S_WR_CTL   | writing control word to start the timer
// S_RUN      | timer running, watching stop / irq / snap_req
// S_WR_CLR   | clearing timeout status, tick pulse
// S_HOLD     | idle cycle while the slave irq falls
// S_SNAP_W   | writing snap_l to latch the live counter
// S_RD_L     | presenting snap_l address
// S_RD_H     | presenting snap_h address, capturing low half
// S_RD_DONE  | capturing high half, snapshot_valid pulse
// S_WR_STOP  | writing stop to control
// S_WR_SCLR  | clearing status after stop
// ---------------------------------------------------------------------------

module timer_sequencer #(
    parameter bit          CONTINUOUS = 1'b1,
    parameter logic [31:0] MIN_PERIOD = 32'd1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [31:0] i_period_in,
    input  logic        i_snap_req,
    output logic [2:0]  o_avm_address,
    output logic        o_avm_chipselect,
    output logic        o_avm_write_n,
    output logic [15:0] o_avm_writedata,
    input  logic [15:0] i_avm_readdata,
    input  logic        i_irq_in,
    output logic        o_tick,
    output logic [15:0] o_tick_count,
    output logic        o_busy,
    output logic [31:0] o_snapshot,
    output logic        o_snapshot_valid
);

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    // control = {stop, start, cont, ito}
    localparam logic [15:0] CTL_START = CONTINUOUS ? 16'h0007 : 16'h0005;
    localparam logic [15:0] CTL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTL,
        S_RUN,
        S_WR_CLR,
        S_HOLD,
        S_SNAP_W,
        S_RD_L,
        S_RD_H,
        S_RD_DONE,
        S_WR_STOP,
        S_WR_SCLR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_stop_pend;
    logic        w_stop_pend_nxt;
    logic        w_stop_now;
    logic [31:0] w_period_clamped;
    logic [31:0] r_period;

    logic [2:0]  w_addr_nxt;
    logic        w_cs_nxt;
    logic        w_wr_n_nxt;
    logic [15:0] w_wdata_nxt;
    logic        w_tick_nxt;

    logic [2:0]  r_avm_address;
    logic        r_avm_chipselect;
    logic        r_avm_write_n;
    logic [15:0] r_avm_writedata;
    logic        r_tick;
    logic [15:0] r_tick_count;
    logic        r_busy;
    logic [31:0] r_snapshot;
    logic        r_snapshot_valid;

    assign w_period_clamped = (i_period_in < MIN_PERIOD) ? MIN_PERIOD : i_period_in;

    // A stop that arrived while the FSM was busy elsewhere counts as if it
    // were present now, at the RUN/HOLD decision point.
    assign w_stop_now = i_stop | r_stop_pend;

    always_comb begin
        w_state_nxt     = r_state;
        w_stop_pend_nxt = 1'b0;

        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_WR_PL;
            S_WR_PL:   w_state_nxt = S_WR_PH;
            S_WR_PH:   w_state_nxt = S_WR_CTL;
            S_WR_CTL:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_stop_now)      w_state_nxt = S_WR_STOP;
                else if (i_irq_in)   w_state_nxt = S_WR_CLR;
                else if (i_snap_req) w_state_nxt = S_SNAP_W;
            end
            S_WR_CLR:  w_state_nxt = S_HOLD;
            // irq_in is still high here from the timeout just cleared.
            S_HOLD: begin
                if (w_stop_now)      w_state_nxt = S_WR_STOP;
                else if (CONTINUOUS) w_state_nxt = S_RUN;
                else                 w_state_nxt = S_IDLE;
            end
            S_SNAP_W:  w_state_nxt = S_RD_L;
            S_RD_L:    w_state_nxt = S_RD_H;
            S_RD_H:    w_state_nxt = S_RD_DONE;
            S_RD_DONE: w_state_nxt = S_RUN;
            S_WR_STOP: w_state_nxt = S_WR_SCLR;
            S_WR_SCLR: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        case (r_state)
            S_WR_PL, S_WR_PH, S_WR_CTL, S_WR_CLR,
            S_SNAP_W, S_RD_L, S_RD_H, S_RD_DONE:
                w_stop_pend_nxt = r_stop_pend | i_stop;
            default:
                w_stop_pend_nxt = 1'b0;
        endcase

        // Bus and tick are decoded from the state being entered so that the
        // registered outputs line up with that state's cycle.
        w_addr_nxt  = 3'd0;
        w_cs_nxt    = 1'b0;
        w_wr_n_nxt  = 1'b1;
        w_wdata_nxt = 16'h0000;
        w_tick_nxt  = 1'b0;

        case (w_state_nxt)
            S_WR_PL: begin
                // r_period is only loaded on this same edge, so use the
                // clamped input directly.
                w_addr_nxt  = ADDR_PERIOD_L;
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = w_period_clamped[15:0];
            end
            S_WR_PH: begin
                w_addr_nxt  = ADDR_PERIOD_H;
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = r_period[31:16];
            end
            S_WR_CTL: begin
                w_addr_nxt  = ADDR_CONTROL;
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = CTL_START;
            end
            S_WR_CLR: begin
                w_addr_nxt  = ADDR_STATUS;
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = 16'h0000;
                w_tick_nxt  = 1'b1;
            end
            S_SNAP_W: begin
                w_addr_nxt  = ADDR_SNAP_L;
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = 16'h0000;
            end
            S_RD_L: begin
                w_addr_nxt  = ADDR_SNAP_L;
            end
            S_RD_H: begin
                w_addr_nxt  = ADDR_SNAP_H;
            end
            S_WR_STOP: begin
                w_addr_nxt  = ADDR_CONTROL;
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = CTL_STOP;
            end
            S_WR_SCLR: begin
                w_addr_nxt  = ADDR_STATUS;
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = 16'h0000;
            end
            default: begin
                w_addr_nxt  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_avm_address    <= 3'd0;
            r_avm_chipselect <= 1'b0;
            r_avm_write_n    <= 1'b1;
            r_avm_writedata  <= 16'h0000;
            r_tick           <= 1'b0;
            r_tick_count     <= 16'h0000;
            r_busy           <= 1'b0;
            r_snapshot       <= 32'h0000_0000;
            r_snapshot_valid <= 1'b0;
            r_period         <= 32'h0000_0000;
        end else begin
            r_avm_address    <= w_addr_nxt;
            r_avm_chipselect <= w_cs_nxt;
            r_avm_write_n    <= w_wr_n_nxt;
            r_avm_writedata  <= w_wdata_nxt;
            r_tick           <= w_tick_nxt;
            r_busy           <= (w_state_nxt != S_IDLE);
            r_snapshot_valid <= (r_state == S_RD_DONE);

            if (r_state == S_IDLE && i_start) begin
                r_period     <= w_period_clamped;
                r_tick_count <= 16'h0000;
            end else if (w_state_nxt == S_WR_CLR) begin
                r_tick_count <= r_tick_count + 16'd1;
            end

            // Read data trails the address by one cycle: snap_l arrives
            // while snap_h is being addressed, snap_h one cycle later.
            if (r_state == S_RD_H) begin
                r_snapshot[15:0] <= i_avm_readdata;
            end
            if (r_state == S_RD_DONE) begin
                r_snapshot[31:16] <= i_avm_readdata;
            end
        end
    end

    assign o_avm_address    = r_avm_address;
    assign o_avm_chipselect = r_avm_chipselect;
    assign o_avm_write_n    = r_avm_write_n;
    assign o_avm_writedata  = r_avm_writedata;
    assign o_tick           = r_tick;
    assign o_tick_count     = r_tick_count;
    assign o_busy           = r_busy;
    assign o_snapshot       = r_snapshot;
    assign o_snapshot_valid = r_snapshot_valid;

endmodule

// File: tb/tb_timer_sequencer.sv
module tb_timer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // periodic instance
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period_in = 32'h0;
    logic        snap_req = 1'b0;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] readdata = 16'h0;
    logic        tick;
    logic [15:0] tick_count;
    logic        busy;
    logic [31:0] snapshot;
    logic        snapshot_valid;

    // one-shot instance
    logic        os_start = 1'b0;
    logic        os_stop = 1'b0;
    logic [31:0] os_period = 32'h0;
    logic        os_snap = 1'b0;
    logic        os_irq = 1'b0;
    logic [15:0] os_readdata = 16'h0;
    logic [2:0]  os_address;
    logic        os_chipselect;
    logic        os_write_n;
    logic [15:0] os_writedata;
    logic        os_tick;
    logic [15:0] os_tick_count;
    logic        os_busy;
    logic [31:0] os_snapshot;
    logic        os_snapshot_valid;

    // slave model
    logic        irq_set = 1'b0;
    logic        irq_flag = 1'b0;
    logic        clr_pend = 1'b0;
    logic [31:0] slave_cnt = 32'h0;
    logic [31:0] snap_reg = 32'h0;

    timer_sequencer #(.CONTINUOUS(1'b1), .MIN_PERIOD(32'd1)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
        .i_period_in(period_in), .i_snap_req(snap_req),
        .o_avm_address(avm_address), .o_avm_chipselect(avm_chipselect),
        .o_avm_write_n(avm_write_n), .o_avm_writedata(avm_writedata),
        .i_avm_readdata(readdata), .i_irq_in(irq_flag),
        .o_tick(tick), .o_tick_count(tick_count), .o_busy(busy),
        .o_snapshot(snapshot), .o_snapshot_valid(snapshot_valid)
    );

    timer_sequencer #(.CONTINUOUS(1'b0), .MIN_PERIOD(32'd1)) u_dut_os (
        .i_clk(clk), .i_reset(reset), .i_start(os_start), .i_stop(os_stop),
        .i_period_in(os_period), .i_snap_req(os_snap),
        .o_avm_address(os_address), .o_avm_chipselect(os_chipselect),
        .o_avm_write_n(os_write_n), .o_avm_writedata(os_writedata),
        .i_avm_readdata(os_readdata), .i_irq_in(os_irq),
        .o_tick(os_tick), .o_tick_count(os_tick_count), .o_busy(os_busy),
        .o_snapshot(os_snapshot), .o_snapshot_valid(os_snapshot_valid)
    );

    // Slave: irq falls one edge after the status write completes; snap_l
    // write latches the live counter; read data is registered.
    always @(posedge clk) begin
        clr_pend <= avm_chipselect && !avm_write_n && (avm_address == 3'd0);
        if (irq_set)       irq_flag <= 1'b1;
        else if (clr_pend) irq_flag <= 1'b0;
        if (avm_chipselect && !avm_write_n && (avm_address == 3'd4))
            snap_reg <= slave_cnt;
        case (avm_address)
            3'd4:    readdata <= snap_reg[15:0];
            3'd5:    readdata <= snap_reg[31:16];
            default: readdata <= 16'h0;
        endcase
    end

    // Monitors (sampled away from the active edge)
    logic [18:0] wq[$];
    int tick_seen = 0;
    int snapv_seen = 0;
    always @(negedge clk) begin
        if (!reset && avm_chipselect && !avm_write_n) wq.push_back({avm_address, avm_writedata});
        if (tick) tick_seen++;
        if (snapshot_valid) snapv_seen++;
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_tcnt = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_bus(input string tag, input logic cs, input logic wn,
                           input logic [2:0] a, input logic [15:0] d);
        chk({tag, "_bus"}, {11'h0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
            {11'h0, cs, wn, a, d});
    endtask

    task automatic chk_ctl(input string tag, input logic cs, input logic wn, input logic [2:0] a);
        chk({tag, "_ctl"}, {27'h0, avm_chipselect, avm_write_n, avm_address}, {27'h0, cs, wn, a});
    endtask

    task automatic chk_os_bus(input string tag, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [15:0] d);
        chk({tag, "_bus"}, {11'h0, os_chipselect, os_write_n, os_address, os_writedata},
            {11'h0, cs, wn, a, d});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_bus(tag, 1'b0, 1'b1, 3'd0, 16'h0);
        chk({tag, "_tick"}, {31'h0, tick}, 32'h0);
        chk({tag, "_tcnt"}, {16'h0, tick_count}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_snap"}, snapshot, 32'h0);
        chk({tag, "_snapv"}, {31'h0, snapshot_valid}, 32'h0);
    endtask

    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p < 32'd1) ? 32'd1 : p;
    endfunction

    // Raise one timeout while in RUN and follow the service sequence.
    task automatic service_irq(input string tag);
        irq_set = 1'b1;
        step();
        irq_set = 1'b0;
        step();
        exp_tcnt = exp_tcnt + 16'd1;
        chk({tag, "_tick"}, {31'h0, tick}, 32'h1);
        chk_bus({tag, "_clr"}, 1'b1, 1'b0, 3'd0, 16'h0);
        chk({tag, "_tcnt"}, {16'h0, tick_count}, {16'h0, exp_tcnt});
        step();
        chk({tag, "_hold_tick"}, {31'h0, tick}, 32'h0);
        chk_bus({tag, "_hold"}, 1'b0, 1'b1, 3'd0, 16'h0);
        step();
        chk({tag, "_run_tick"}, {31'h0, tick}, 32'h0);
        chk({tag, "_run_busy"}, {31'h0, busy}, 32'h1);
    endtask

    task automatic do_snapshot(input string tag, input logic [31:0] value);
        slave_cnt = value;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        chk_ctl({tag, "_w"}, 1'b1, 1'b0, 3'd4);
        step();
        chk_ctl({tag, "_rl"}, 1'b0, 1'b1, 3'd4);
        chk({tag, "_v1"}, {31'h0, snapshot_valid}, 32'h0);
        step();
        chk_ctl({tag, "_rh"}, 1'b0, 1'b1, 3'd5);
        step();
        chk({tag, "_v3"}, {31'h0, snapshot_valid}, 32'h0);
        step();
        chk({tag, "_v4"}, {31'h0, snapshot_valid}, 32'h1);
        chk({tag, "_val"}, snapshot, value);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
        step();
        chk({tag, "_v5"}, {31'h0, snapshot_valid}, 32'h0);
        chk_bus({tag, "_idle"}, 1'b0, 1'b1, 3'd0, 16'h0);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: run did not complete within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_w;
        int base_t;
        int base_v;
        logic [31:0] p;
        logic [31:0] pc;
        int k;
        logic [18:0] exp_q[$];

        // Reset values
        step(3);
        chk_reset_outputs("rst");
        chk("rst_os_busy", {31'h0, os_busy}, 32'h0);
        reset = 1'b0;
        step();

        // One-shot with clamp: period 0 -> 1, control 0x0005
        os_period = 32'h0;
        os_start = 1'b1;
        step();
        os_start = 1'b0;
        chk_os_bus("os_pl", 1'b1, 1'b0, 3'd2, 16'h0001);
        chk("os_busy0", {31'h0, os_busy}, 32'h1);
        step();
        chk_os_bus("os_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
        step();
        chk_os_bus("os_ctl", 1'b1, 1'b0, 3'd1, 16'h0005);
        step();
        chk_os_bus("os_run", 1'b0, 1'b1, 3'd0, 16'h0);
        os_irq = 1'b1;
        step();
        chk("os_tick", {31'h0, os_tick}, 32'h1);
        chk_os_bus("os_clr", 1'b1, 1'b0, 3'd0, 16'h0);
        chk("os_tcnt", {16'h0, os_tick_count}, 32'h1);
        step();
        chk("os_hold_tick", {31'h0, os_tick}, 32'h0);
        chk("os_hold_busy", {31'h0, os_busy}, 32'h1);
        os_irq = 1'b0;
        step();
        chk("os_idle_busy", {31'h0, os_busy}, 32'h0);
        os_irq = 1'b1;
        step(2);
        chk("os_idle_tick", {31'h0, os_tick}, 32'h0);
        chk("os_idle_busy2", {31'h0, os_busy}, 32'h0);
        os_irq = 1'b0;

        // stop and snap_req in IDLE are ignored
        base_w = wq.size();
        base_v = snapv_seen;
        stop = 1'b1;
        step();
        stop = 1'b0;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step(5);
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("idle_writes", wq.size() - base_w, 32'h0);
        chk("idle_snapv", snapv_seen - base_v, 32'h0);

        // Program 0x0001_2345
        period_in = 32'h0001_2345;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_bus("prog_pl", 1'b1, 1'b0, 3'd2, 16'h2345);
        chk("prog_busy1", {31'h0, busy}, 32'h1);
        step();
        chk_bus("prog_ph", 1'b1, 1'b0, 3'd3, 16'h0001);
        chk("prog_busy2", {31'h0, busy}, 32'h1);
        step();
        chk_bus("prog_ctl", 1'b1, 1'b0, 3'd1, 16'h0007);
        chk("prog_busy3", {31'h0, busy}, 32'h1);
        step();
        chk_bus("prog_run", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("prog_busy4", {31'h0, busy}, 32'h1);
        exp_tcnt = 16'h0;
        // start while busy is ignored
        base_w = wq.size();
        period_in = 32'h0000_FFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("busy_start_writes", wq.size() - base_w, 32'h0);

        // Periodic service x3 with random gaps
        base_w = wq.size();
        base_t = tick_seen;
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(0, 4));
            service_irq("per");
        end
        step();
        chk("per_ticks", tick_seen - base_t, 32'd3);
        chk("per_tcnt", {16'h0, tick_count}, 32'd3);
        chk("per_writes", wq.size() - base_w, 32'd3);
        for (int i = 0; i < 3; i++)
            if (base_w + i < wq.size())
                chk("per_wr", {13'h0, wq[base_w + i]}, 32'h0);

        // tick_count wrap: preload the counter at its top value
        u_dut.r_tick_count <= 16'hFFFF;
        step();
        chk("wrap_pre", {16'h0, tick_count}, 32'h0000_FFFF);
        exp_tcnt = 16'hFFFF;
        service_irq("wrap");
        chk("wrap_zero", {16'h0, tick_count}, 32'h0);

        // Snapshots
        do_snapshot("snap0", 32'hABCD_1234);
        do_snapshot("snap1", $urandom);
        step($urandom_range(0, 3));
        do_snapshot("snap2", $urandom);

        service_irq("post");

        // Stop beats irq in the same RUN cycle
        base_t = tick_seen;
        irq_set = 1'b1;
        step();
        irq_set = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_bus("sp_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
        chk("sp_tick", {31'h0, tick}, 32'h0);
        step();
        chk_bus("sp_sclr", 1'b1, 1'b0, 3'd0, 16'h0000);
        step();
        chk_bus("sp_idle", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("sp_busy", {31'h0, busy}, 32'h0);
        chk("sp_ticks", tick_seen - base_t, 32'h0);
        chk("sp_tcnt", {16'h0, tick_count}, {16'h0, exp_tcnt});
        step(2);

        // Stop during WR_PH is held until RUN
        period_in = 32'h0000_0010;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_bus("ph_pl", 1'b1, 1'b0, 3'd2, 16'h0010);
        chk("ph_tcnt_clr", {16'h0, tick_count}, 32'h0);
        step();
        chk_bus("ph_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_bus("ph_ctl", 1'b1, 1'b0, 3'd1, 16'h0007);
        step();
        chk_bus("ph_run", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("ph_run_busy", {31'h0, busy}, 32'h1);
        step();
        chk_bus("ph_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
        step();
        chk_bus("ph_sclr", 1'b1, 1'b0, 3'd0, 16'h0000);
        step();
        chk("ph_busy", {31'h0, busy}, 32'h0);
        step();

        // Randomized sessions against the write-sequence model
        for (int r = 0; r < 5; r++) begin
            p = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            pc = clamp_period(p);
            k = $urandom_range(0, 3);
            exp_q.delete();
            exp_q.push_back({3'd2, pc[15:0]});
            exp_q.push_back({3'd3, pc[31:16]});
            exp_q.push_back({3'd1, 16'h0007});
            for (int j = 0; j < k; j++) exp_q.push_back({3'd0, 16'h0000});
            exp_q.push_back({3'd1, 16'h0008});
            exp_q.push_back({3'd0, 16'h0000});

            base_w = wq.size();
            period_in = p;
            start = 1'b1;
            step();
            start = 1'b0;
            step(3);
            exp_tcnt = 16'h0;
            for (int j = 0; j < k; j++) begin
                step($urandom_range(0, 3));
                service_irq("rnd");
            end
            stop = 1'b1;
            step();
            stop = 1'b0;
            step(3);
            chk("rnd_busy", {31'h0, busy}, 32'h0);
            chk("rnd_tcnt", {16'h0, tick_count}, k);
            chk("rnd_nwr", wq.size() - base_w, exp_q.size());
            for (int j = 0; j < exp_q.size(); j++)
                if (base_w + j < wq.size())
                    chk("rnd_wr", {13'h0, wq[base_w + j]}, {13'h0, exp_q[j]});
        end

        // Reset in RD_H abandons the snapshot read
        period_in = 32'h5;
        start = 1'b1;
        step();
        start = 1'b0;
        step(3);
        exp_tcnt = 16'h0;
        service_irq("rh");
        slave_cnt = 32'h1357_9BDF;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step(2);
        chk_ctl("rh_state", 1'b0, 1'b1, 3'd5);
        reset = 1'b1;
        step();
        chk_reset_outputs("rh_rst");
        reset = 1'b0;
        step();
        chk("rh_idle", {31'h0, busy}, 32'h0);
        period_in = 32'h7;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_bus("rh_restart", 1'b1, 1'b0, 3'd2, 16'h0007);
        step(3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step(3);
        chk("rh_end_busy", {31'h0, busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
